// File: rtl/nvdla_scan_chain_ctrl_if.sv
// ==== nvdla_scan_chain_ctrl_if: pattern request / result handshake bundle ====
// Revision: 1.0 -- res_sig present only with NVDLA_SCAN_CTRL_MISR_EN
`default_nettype none

interface nvdla_scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 8
);
  logic                 pat_valid;
  logic                 pat_ready;
  logic [CHAIN_LEN-1:0] pat_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [CHAIN_LEN-1:0] res_data;
`ifdef NVDLA_SCAN_CTRL_MISR_EN
  logic [15:0]          res_sig;
`endif

  modport master (
    output pat_valid, pat_data, res_ready,
    input  pat_ready, res_valid, res_data
`ifdef NVDLA_SCAN_CTRL_MISR_EN
    , input res_sig
`endif
  );

  modport slave (
    input  pat_valid, pat_data, res_ready,
    output pat_ready, res_valid, res_data
`ifdef NVDLA_SCAN_CTRL_MISR_EN
    , output res_sig
`endif
  );
endinterface

`default_nettype wire

// File: rtl/nvdla_scan_chain_ctrl.sv
// ==== nvdla_scan_chain_ctrl: load / capture / unload sequencer for one scan chain ====
// Revision: 1.0 -- optional CRC-16 signature via NVDLA_SCAN_CTRL_MISR_EN
`default_nettype none

module nvdla_scan_chain_ctrl #(
  parameter int   CHAIN_LEN = 8,
  parameter logic FILL_BIT  = 1'b1
) (
  input  wire logic               nvdla_core_clk,
  input  wire logic               nvdla_core_rstn,
  input  wire logic               abort,
  output logic                    scan_se,
  output logic                    scan_si,
  input  wire logic               scan_so,
  output logic                    busy,
  nvdla_scan_chain_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [CHAIN_LEN-1:0] r_pat_sr;
  logic [CHAIN_LEN-2:0] r_res_shift;
  logic [CHAIN_LEN-1:0] r_res_data;
  logic [CHAIN_LEN-1:0] w_res_nxt;
  logic                 w_accept;
  logic                 w_si_nxt;

  assign w_accept      = bus.pat_valid && (r_state == ST_IDLE);
  assign w_res_nxt     = {r_res_shift, scan_so};
  assign bus.pat_ready = (r_state == ST_IDLE);
  assign bus.res_valid = (r_state == ST_DONE);
  assign bus.res_data  = r_res_data;
  assign busy          = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.pat_valid) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = CNT_W'(CHAIN_LEN - 1);
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_UNLOAD;
          w_cnt_nxt   = CNT_W'(CHAIN_LEN - 1);
        end
      end
      ST_UNLOAD: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.res_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // scan_si is precomputed one cycle ahead so the chain sees it straight from a flop.
  always_comb begin
    w_si_nxt = FILL_BIT;
    if (w_accept)
      w_si_nxt = bus.pat_data[CHAIN_LEN-1];
    else if ((r_state == ST_LOAD) && (w_state_nxt == ST_LOAD))
      w_si_nxt = r_pat_sr[CHAIN_LEN-2];
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      scan_se     <= 1'b0;
      scan_si     <= FILL_BIT;
      r_pat_sr    <= '0;
      r_res_shift <= '0;
      r_res_data  <= '0;
    end else begin
      scan_se <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_UNLOAD);
      scan_si <= w_si_nxt;
      if (w_accept)
        r_pat_sr <= bus.pat_data;
      else if (r_state == ST_LOAD)
        r_pat_sr <= {r_pat_sr[CHAIN_LEN-2:0], r_pat_sr[CHAIN_LEN-1]};
      if (r_state == ST_UNLOAD)
        r_res_shift <= w_res_nxt[CHAIN_LEN-2:0];
      if ((r_state == ST_UNLOAD) && (w_state_nxt == ST_DONE))
        r_res_data <= w_res_nxt;
    end
  end

`ifdef NVDLA_SCAN_CTRL_MISR_EN
  logic [15:0] r_sig;
  logic        w_fb;

  assign w_fb        = r_sig[15] ^ scan_so;
  assign bus.res_sig = r_sig;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)
      r_sig <= 16'hFFFF;
    else if (w_accept)
      r_sig <= 16'hFFFF;
    else if (r_state == ST_UNLOAD)
      r_sig <= {r_sig[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_nvdla_scan_chain_ctrl.sv
// ==== tb_nvdla_scan_chain_ctrl: directed bench with an 8-cell D=~Q chain model ====
// Revision: 1.0
`default_nettype none

module tb_nvdla_scan_chain_ctrl;
  logic clk = 1'b0;
  logic rstn;
  logic abort;
  logic scan_se, scan_si, scan_so, busy;
  logic [7:0] chain;

  int n_chk  = 0;
  int n_fail = 0;

  logic [19:0] se_tr, si_tr, rv_tr;
  logic [7:0]  rd18;
`ifdef NVDLA_SCAN_CTRL_MISR_EN
  logic [15:0] sig18;
`endif

  always #5 clk = ~clk;

  nvdla_scan_chain_ctrl_if #(.CHAIN_LEN(8)) bus ();

  nvdla_scan_chain_ctrl #(.CHAIN_LEN(8), .FILL_BIT(1'b1)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .abort           (abort),
    .scan_se         (scan_se),
    .scan_si         (scan_si),
    .scan_so         (scan_so),
    .busy            (busy),
    .bus             (bus.slave)
  );

  // Async-set cells; the functional D of every cell is its own inverted Q.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        chain <= 8'hFF;
    else if (scan_se) chain <= {chain[6:0], scan_si};
    else              chain <= ~chain;
  end
  assign scan_so = chain[7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] p);
    bus.pat_valid = 1'b1;
    bus.pat_data  = p;
    tick();
    bus.pat_valid = 1'b0;
  endtask

  // Samples cycles 1..last of the current transaction; ends sitting in cycle 'last'.
  task automatic collect(input int last);
    se_tr = '0; si_tr = '0; rv_tr = '0; rd18 = '0;
    for (int c = 1; c <= last; c++) begin
      se_tr[c] = scan_se;
      si_tr[c] = scan_si;
      rv_tr[c] = bus.res_valid;
      if (c == 18) begin
        rd18 = bus.res_data;
`ifdef NVDLA_SCAN_CTRL_MISR_EN
        sig18 = bus.res_sig;
`endif
      end
      if (c < last) tick();
    end
  endtask

  initial begin
    logic seen;
    rstn = 1'b0; abort = 1'b0;
    bus.pat_valid = 1'b0; bus.pat_data = '0; bus.res_ready = 1'b1;
    #23;
    check("rst_se",    32'(scan_se),       32'h0);
    check("rst_si",    32'(scan_si),       32'h1);
    check("rst_rv",    32'(bus.res_valid), 32'h0);
    check("rst_rd",    32'(bus.res_data),  32'h0);
    check("rst_busy",  32'(busy),          32'h0);
    check("rst_ready", 32'(bus.pat_ready), 32'h1);
    rstn = 1'b1;
    tick();

    // A5 with immediate consumption
    start(8'hA5);
    check("t1_busy_c1", 32'(busy), 32'h1);
    collect(18);
    check("t1_se_trace", 32'(se_tr), 32'h3FDFE);
    check("t1_rv_trace", 32'(rv_tr), 32'h40000);
    check("t1_res",      32'(rd18),  32'h5A);
`ifdef NVDLA_SCAN_CTRL_MISR_EN
    check("t1_sig",      32'(sig18), 32'h1A4F);
`endif
    tick();
    check("t1_ready_c19", 32'(bus.pat_ready), 32'h1);
    check("t1_busy_c19",  32'(busy),          32'h0);
    check("t1_rd_hold",   32'(bus.res_data),  32'h5A);

    // 80: scan_si bit ordering and fill, capture cycle masked out
    start(8'h80);
    collect(18);
    check("t2_si_trace", 32'(si_tr & 20'h3FDFE), 32'h3FC02);
    check("t2_res",      32'(rd18),              32'h7F);
    tick();

    // back-pressure on the result
    bus.res_ready = 1'b0;
    start(8'h0F);
    collect(18);
    check("t3_rv_c18", 32'(rv_tr[18]), 32'h1);
    for (int h = 0; h < 5; h++) begin
      check("t3_hold_rv",    32'(bus.res_valid), 32'h1);
      check("t3_hold_rd",    32'(bus.res_data),  32'hF0);
      check("t3_hold_ready", 32'(bus.pat_ready), 32'h0);
      bus.pat_valid = 1'b1;
      bus.pat_data  = 8'hF0;
      tick();
    end
    bus.res_ready = 1'b1;
    check("t3_rv_c23", 32'(bus.res_valid), 32'h1);
    tick();
    check("t3_rv_c24",    32'(bus.res_valid), 32'h0);
    check("t3_ready_c24", 32'(bus.pat_ready), 32'h1);
    tick();
    bus.pat_valid = 1'b0;
    check("t3_next_busy", 32'(busy),    32'h1);
    check("t3_next_se",   32'(scan_se), 32'h1);
    check("t3_next_si",   32'(scan_si), 32'h1);
    collect(18);
    check("t3_next_res", 32'(rd18), 32'h0F);
    tick();

    // abort in LOAD cycle 4
    start(8'hFF);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_se_c5",    32'(scan_se),       32'h0);
    check("t4_busy_c5",  32'(busy),          32'h0);
    check("t4_ready_c5", 32'(bus.pat_ready), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid) seen = 1'b1;
      tick();
    end
    check("t4_no_rv", 32'(seen), 32'h0);
    start(8'h3C);
    collect(18);
    check("t4_res", 32'(rd18), 32'hC3);
    tick();

    // reset pulse during UNLOAD
    start(8'hA5);
    collect(12);
    rstn = 1'b0;
    #1;
    check("t5_se",    32'(scan_se),       32'h0);
    check("t5_si",    32'(scan_si),       32'h1);
    check("t5_rv",    32'(bus.res_valid), 32'h0);
    check("t5_rd",    32'(bus.res_data),  32'h0);
    check("t5_busy",  32'(busy),          32'h0);
`ifdef NVDLA_SCAN_CTRL_MISR_EN
    check("t5_sig",   32'(bus.res_sig),   32'hFFFF);
`endif
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.res_valid || busy) seen = 1'b1;
    end
    check("t5_no_rv", 32'(seen), 32'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/nvdla_scan_chain_ctrl.md
Name: nvdla_scan_chain_ctrl

Overview:
- Sequences one serial scan chain of async-set scan flops (SI/D/SE/CP/SDN style cells, SI of cell 0 driven by the block, Q of last cell returned as scan_so).
- Per transaction: accepts a parallel pattern, shifts it into the chain, pulses one functional capture cycle, shifts the captured state back out, and returns it as a parallel result.
- Used for register-file self-test and for save/restore of config flop chains in the core clock domain.

Parameters:
- CHAIN_LEN, 8, number of scan cells in the chain; legal 2..64.
- FILL_BIT, 1'b1, value driven on scan_si while unloading; matches the cell set value.
- CNT_W, $clog2(CHAIN_LEN+1), shift counter width; derived, never overridden.

Ports:
- nvdla_core_clk  input  1  core clock; chain cells share it.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- pat_valid  input  1  pattern request valid.
- pat_ready  output  1  block can accept a pattern.
- pat_data  input  CHAIN_LEN  pattern; bit CHAIN_LEN-1 targets the last cell.
- abort  input  1  synchronous cancel of the current transaction.
- scan_se  output  1  chain scan enable (registered).
- scan_si  output  1  chain serial input (registered).
- scan_so  input  1  Q of the last chain cell.
- res_valid  output  1  result valid.
- res_ready  input  1  result accepted by consumer.
- res_data  output  CHAIN_LEN  captured chain state; bit k = cell k after capture.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (nvdla_core_rstn low, asynchronous): state=IDLE, scan_se=0, scan_si=FILL_BIT, res_valid=0, res_data=0, counter=0, pattern shift register=0, busy=0. Reset asserted mid-transaction discards it; no partial result is ever presented.
- pat_ready = (state==IDLE). A pattern is accepted when pat_valid&&pat_ready; pat_data is latched into the internal shift register that cycle.
- States: IDLE -> LOAD -> CAPTURE -> UNLOAD -> DONE -> IDLE.
- Acceptance cycle = cycle 0. Cycles 1..CHAIN_LEN are LOAD:
  - scan_se=1.
  - scan_si = pattern bits, MSB first: cycle j drives pat_data[CHAIN_LEN-j].
  - After the last LOAD edge, cell k holds pat_data[k].
- Cycle CHAIN_LEN+1 is CAPTURE: scan_se=0 for exactly one cycle; the chain loads its functional D.
- Cycles CHAIN_LEN+2..2*CHAIN_LEN+1 are UNLOAD:
  - scan_se=1, scan_si=FILL_BIT.
  - Each cycle, scan_so is sampled on the same edge that shifts the chain: res_shift = {res_shift[CHAIN_LEN-2:0], scan_so}.
- DONE, from cycle 2*CHAIN_LEN+2:
  - res_valid=1, scan_se=0, res_data stable.
  - Holds until res_ready; on res_valid&&res_ready the block goes to IDLE next cycle and res_valid drops.
  - res_ready high on the first DONE cycle gives a one-cycle result. Minimum request-to-request period is 2*CHAIN_LEN+3 cycles.
- Counter counts CHAIN_LEN-1 down to 0 in LOAD and again in UNLOAD; the state transitions when the counter reaches 0. No wrap-around.
- abort:
  - In LOAD, CAPTURE or UNLOAD: next state IDLE, scan_se=0 next cycle, no result. Chain contents are undefined afterwards.
  - In DONE: ignored; the result must be consumed.
  - In IDLE: ignored. An abort coinciding with pat_valid in IDLE still accepts the pattern.
- scan_se and scan_si come directly from flops (glitch-free toward the chain). busy is combinational from the state.
- res_data is updated only on entry to DONE; it keeps its last value in IDLE.

Optional Feature:
- Macro: NVDLA_SCAN_CTRL_MISR_EN.
- Defined: adds output port res_sig [15:0], a serial CRC-16-CCITT signature over the unloaded bits.
  - Seeded to 16'hFFFF on pattern accept.
  - Each UNLOAD cycle: fb=sig[15]^scan_so; sig={sig[14:0],1'b0}^(fb?16'h1021:16'h0).
  - Presented with res_data in DONE; reset value 16'hFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Bench chain model: CHAIN_LEN=8 cells whose functional D = ~Q. Accept pat_data=8'hA5 with res_ready=1 -> res_data=8'h5A. res_valid rises at cycle 18 and lasts 1 cycle. scan_se is high cycles 1-8, low cycle 9, high cycles 10-17.
- Pattern 8'h80, observe scan_si -> scan_si=1 in cycle 1 and 0 in cycles 2-8. scan_si=1 (FILL_BIT) in cycles 10-17.
- res_ready held low 5 cycles after res_valid -> res_valid and res_data stay stable, pat_ready=0 throughout. The next pattern is accepted the cycle after the res_ready handshake.
- abort asserted in LOAD cycle 4 -> scan_se=0 from cycle 5, state IDLE, no res_valid. A new pattern 8'h3C then completes with 8'hC3.
- nvdla_core_rstn pulsed low during UNLOAD -> all outputs return to reset values immediately. No res_valid after release.
- With NVDLA_SCAN_CTRL_MISR_EN, pattern 8'hA5 -> res_sig equals the golden CRC-16-CCITT (seed FFFF, MSB first) of the 8 unloaded bits 0x5A. Without the macro, the same bench compiles with no res_sig port.
